// File: rtl/xsleena_vram_slot_arbiter.sv
// Time-slot arbiter for the shared single-port video RAM.
// Each 12 MHz tick starts a slot. The slot is owned by video (reserved phases),
// by one of the two CPUs (round-robin on ties), or by nobody.
// The access granted at one tick completes at the next tick. At that second
// tick the read data is captured and the ack or valid pulse is raised, and the
// next slot is decided on the same edge.
//
// CPU handshake, valid/ready style:
//   cpuN_req is the "valid" signal. cpuN_we, cpuN_addr and cpuN_din must stay
//   stable from the assertion of req until cpuN_ack. cpuN_ack is a one-clk
//   "done" pulse that arrives one slot after the grant. The requester must drop
//   req before the next tick after the ack, because a req seen high at a later
//   eligible tick starts a new access. A req dropped before the grant is
//   withdrawn: no access is made and no ack is sent. A req dropped after the
//   grant still completes and still acks.
module xsleena_vram_slot_arbiter #(
  parameter int          AW          = 12,
  parameter int          DW          = 8,
  parameter logic [3:0]  VIDEO_SLOTS = 4'b0101
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          clk_12_cen,
  input  logic [1:0]    hphase,
  // video fetch side
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  // main CPU
  input  logic          cpu0_req,
  input  logic          cpu0_we,
  input  logic [AW-1:0] cpu0_addr,
  input  logic [DW-1:0] cpu0_din,
  output logic [DW-1:0] cpu0_dout,
  output logic          cpu0_ack,
  // sub CPU
  input  logic          cpu1_req,
  input  logic          cpu1_we,
  input  logic [AW-1:0] cpu1_addr,
  input  logic [DW-1:0] cpu1_din,
  output logic [DW-1:0] cpu1_dout,
  output logic          cpu1_ack,
  // RAM macro
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  // debug: current slot owner (0 idle, 1 video, 2 cpu0, 3 cpu1)
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VID  = 2'd1,
    S_CPU0 = 2'd2,
    S_CPU1 = 2'd3
  } owner_t;

  owner_t          r_owner;
  owner_t          w_owner_nxt;
  logic            r_last_grant;   // 0: cpu0 granted last, 1: cpu1 granted last
  logic [AW-1:0]   r_ram_addr;
  logic            r_ram_we;
  logic [DW-1:0]   r_ram_wdata;
  logic [DW-1:0]   r_vid_data;
  logic            r_vid_valid;
  logic [DW-1:0]   r_cpu0_dout;
  logic            r_cpu0_ack;
  logic [DW-1:0]   r_cpu1_dout;
  logic            r_cpu1_ack;

  logic            w_vid_slot;
  logic            w_done0;
  logic            w_done1;
  logic            w_elig0;
  logic            w_elig1;

  // A CPU that owned the slot now ending is acked on this tick. It must not be
  // granted again on the same edge, because its req is still legally high.
  assign w_vid_slot = VIDEO_SLOTS[hphase];
  assign w_done0    = (r_owner == S_CPU0);
  assign w_done1    = (r_owner == S_CPU1);
  assign w_elig0    = cpu0_req & ~w_done0;
  assign w_elig1    = cpu1_req & ~w_done1;

  // Owner state register: it advances only on slot ticks.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_owner <= S_IDLE;
    end else if (clk_12_cen) begin
      r_owner <= w_owner_nxt;
    end
  end

  // Next owner: a video phase always wins, then eligible CPUs round-robin.
  always_comb begin
    w_owner_nxt = S_IDLE;
    if (w_vid_slot) begin
      w_owner_nxt = S_VID;
    end else if (w_elig0 && w_elig1) begin
      w_owner_nxt = r_last_grant ? S_CPU0 : S_CPU1;
    end else if (w_elig0) begin
      w_owner_nxt = S_CPU0;
    end else if (w_elig1) begin
      w_owner_nxt = S_CPU1;
    end
  end

  // Round-robin memory: remembers which CPU got the most recent grant.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_last_grant <= 1'b1;
    end else if (clk_12_cen) begin
      if (w_owner_nxt == S_CPU0) begin
        r_last_grant <= 1'b0;
      end else if (w_owner_nxt == S_CPU1) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  // RAM port registers: they are loaded for the slot that starts at this tick.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
    end else if (clk_12_cen) begin
      case (w_owner_nxt)
        S_VID: begin
          r_ram_addr <= vid_addr;
          r_ram_we   <= 1'b0;
        end
        S_CPU0: begin
          r_ram_addr  <= cpu0_addr;
          r_ram_wdata <= cpu0_din;
          r_ram_we    <= cpu0_we;
        end
        S_CPU1: begin
          r_ram_addr  <= cpu1_addr;
          r_ram_wdata <= cpu1_din;
          r_ram_we    <= cpu1_we;
        end
        default: begin
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  // Completion of the slot that ends at this tick: capture read data and pulse.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
      r_cpu0_dout <= '0;
      r_cpu0_ack  <= 1'b0;
      r_cpu1_dout <= '0;
      r_cpu1_ack  <= 1'b0;
    end else begin
      r_vid_valid <= 1'b0;
      r_cpu0_ack  <= 1'b0;
      r_cpu1_ack  <= 1'b0;
      if (clk_12_cen) begin
        case (r_owner)
          S_VID: begin
            r_vid_data  <= ram_rdata;
            r_vid_valid <= 1'b1;
          end
          S_CPU0: begin
            if (!r_ram_we) begin
              r_cpu0_dout <= ram_rdata;
            end
            r_cpu0_ack <= 1'b1;
          end
          S_CPU1: begin
            if (!r_ram_we) begin
              r_cpu1_dout <= ram_rdata;
            end
            r_cpu1_ack <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign vid_data  = r_vid_data;
  assign vid_valid = r_vid_valid;
  assign cpu0_dout = r_cpu0_dout;
  assign cpu0_ack  = r_cpu0_ack;
  assign cpu1_dout = r_cpu1_dout;
  assign cpu1_ack  = r_cpu1_ack;
  assign owner     = r_owner;

endmodule

// File: tb/tb_xsleena_vram_slot_arbiter.sv
// Bench for the VRAM slot arbiter: a directed table, hand-written corner cases,
// and randomized CPU traffic checked against a slot-level reference model.
module tb_xsleena_vram_slot_arbiter;

  localparam int         O_IDLE = 0;
  localparam int         O_VID  = 1;
  localparam int         O_CPU0 = 2;
  localparam int         O_CPU1 = 3;
  localparam logic [3:0] VS     = 4'b0101;

  // ---------------- clock / reset ----------------
  logic clk;
  logic RSTn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        clk_12_cen;
  logic [1:0]  hphase;
  logic [11:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu0_req, cpu0_we, cpu0_ack;
  logic [11:0] cpu0_addr;
  logic [7:0]  cpu0_din, cpu0_dout;
  logic        cpu1_req, cpu1_we, cpu1_ack;
  logic [11:0] cpu1_addr;
  logic [7:0]  cpu1_din, cpu1_dout;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [1:0]  owner;

  xsleena_vram_slot_arbiter dut (
    .clk        (clk),
    .RSTn       (RSTn),
    .clk_12_cen (clk_12_cen),
    .hphase     (hphase),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid),
    .cpu0_req   (cpu0_req),
    .cpu0_we    (cpu0_we),
    .cpu0_addr  (cpu0_addr),
    .cpu0_din   (cpu0_din),
    .cpu0_dout  (cpu0_dout),
    .cpu0_ack   (cpu0_ack),
    .cpu1_req   (cpu1_req),
    .cpu1_we    (cpu1_we),
    .cpu1_addr  (cpu1_addr),
    .cpu1_din   (cpu1_din),
    .cpu1_dout  (cpu1_dout),
    .cpu1_ack   (cpu1_ack),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .owner      (owner)
  );

  // ---------------- RAM model ----------------
  function automatic logic [7:0] init_val(input int a);
    logic [11:0] av;
    logic [7:0]  v;
    av = a[11:0];
    if (av == 12'h123) return 8'hA5;
    v = av[7:0] * 8'd29;
    v = v ^ {av[11:8], av[3:0]};
    return v;
  endfunction

  logic [7:0] mem [0:4095];
  logic       mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  // ---------------- scoreboard counters ----------------
  int n_checks;
  int n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (slot level) ----------------
  // One slot record: who owns it and what it does. Writes are committed to the
  // shadow memory when they are granted. Reads take their value from the shadow
  // memory when the slot retires.
  logic [7:0] ref_mem [0:4095];
  int m_owner, m_addr, m_wdata, m_last;
  bit m_we;
  int e_dout0, e_dout1, e_vid;
  bit e_ack0, e_ack1, e_vv;

  task automatic model_reset();
    m_owner = O_IDLE; m_addr = 0; m_wdata = 0; m_we = 0; m_last = 1;
    e_dout0 = 0; e_dout1 = 0; e_vid = 0;
    e_ack0 = 0; e_ack1 = 0; e_vv = 0;
  endtask

  task automatic model_step();
    bit retired0, retired1, want0, want1;
    int pick;
    if (!RSTn) begin
      model_reset();
      return;
    end
    e_ack0 = 0; e_ack1 = 0; e_vv = 0;
    if (!clk_12_cen) return;
    retired0 = 0; retired1 = 0;
    // retire the slot that just ended
    if (m_owner == O_VID) begin
      e_vid = int'(ref_mem[m_addr]); e_vv = 1;
    end else if (m_owner == O_CPU0) begin
      if (!m_we) e_dout0 = int'(ref_mem[m_addr]);
      e_ack0 = 1; retired0 = 1;
    end else if (m_owner == O_CPU1) begin
      if (!m_we) e_dout1 = int'(ref_mem[m_addr]);
      e_ack1 = 1; retired1 = 1;
    end
    // schedule the slot that starts now
    if (((VS >> hphase) & 4'd1) != 4'd0) begin
      m_owner = O_VID; m_addr = int'(vid_addr); m_we = 0;
    end else begin
      want0 = cpu0_req && !retired0;
      want1 = cpu1_req && !retired1;
      pick = -1;
      if (want0 && want1) pick = (m_last == 0) ? 1 : 0;
      else if (want0)     pick = 0;
      else if (want1)     pick = 1;
      if (pick == 0) begin
        m_owner = O_CPU0; m_addr = int'(cpu0_addr); m_wdata = int'(cpu0_din);
        m_we = cpu0_we; m_last = 0;
      end else if (pick == 1) begin
        m_owner = O_CPU1; m_addr = int'(cpu1_addr); m_wdata = int'(cpu1_din);
        m_we = cpu1_we; m_last = 1;
      end else begin
        m_owner = O_IDLE; m_we = 0;
      end
      if (pick >= 0 && m_we) ref_mem[m_addr] = m_wdata[7:0];
    end
  endtask

  task automatic compare_all();
    chk("ram_we",    ram_we,    m_we);
    chk("ram_addr",  ram_addr,  m_addr);
    chk("ram_wdata", ram_wdata, m_wdata);
    chk("owner",     owner,     m_owner);
    chk("vid_valid", vid_valid, e_vv);
    chk("vid_data",  vid_data,  e_vid);
    chk("cpu0_ack",  cpu0_ack,  e_ack0);
    chk("cpu1_ack",  cpu1_ack,  e_ack1);
    chk("cpu0_dout", cpu0_dout, e_dout0);
    chk("cpu1_dout", cpu1_dout, e_dout1);
  endtask

  // ---------------- driver tasks ----------------
  int         div;
  logic [1:0] ph;
  bit         cen_en;

  // One clk: drive the slot enable and phase at the negedge, then sample 1 ns
  // after the posedge.
  task automatic step();
    @(negedge clk);
    clk_12_cen = cen_en && (div == 0);
    hphase     = ph;
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    if (clk_12_cen) ph = ph + 2'd1;
    div = (div + 1) % 4;
  endtask

  // Advance until the next step will be a tick with the given phase.
  task automatic run_until(input logic [1:0] target);
    for (int k = 0; k < 20; k++) begin
      if (div == 0 && ph == target) return;
      step();
    end
  endtask

  task automatic wait_ack(input int which, output bit seen);
    seen = 0;
    for (int k = 0; k < 24 && !seen; k++) begin
      step();
      if (which == 0 && cpu0_ack) seen = 1;
      if (which == 1 && cpu1_ack) seen = 1;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit r0;
    bit r1;
    int own;
    bit a0;
    bit a1;
    bit vv;
  } vec_t;
  vec_t tbl [19];

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int we_cnt, pulses;
    bit seen;

    n_checks = 0; n_err = 0;
    RSTn = 1'b0; mem_load = 1'b1; cen_en = 1;
    div = 0; ph = 2'd0;
    clk_12_cen = 1'b0; hphase = 2'd0; vid_addr = 12'h010;
    cpu0_req = 1'b1; cpu0_we = 1'b0; cpu0_addr = 12'h123; cpu0_din = 8'h00;
    cpu1_req = 1'b1; cpu1_we = 1'b1; cpu1_addr = 12'h7FF; cpu1_din = 8'h3C;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    model_reset();

    tbl[ 0] = '{1'b1, 1'b1, O_VID,  1'b0, 1'b0, 1'b0};
    tbl[ 1] = '{1'b1, 1'b1, O_CPU0, 1'b0, 1'b0, 1'b1};
    tbl[ 2] = '{1'b1, 1'b1, O_VID,  1'b1, 1'b0, 1'b0};
    tbl[ 3] = '{1'b0, 1'b1, O_CPU1, 1'b0, 1'b0, 1'b1};
    tbl[ 4] = '{1'b0, 1'b1, O_VID,  1'b0, 1'b1, 1'b0};
    tbl[ 5] = '{1'b1, 1'b1, O_CPU0, 1'b0, 1'b0, 1'b1};
    tbl[ 6] = '{1'b1, 1'b1, O_VID,  1'b1, 1'b0, 1'b0};
    tbl[ 7] = '{1'b0, 1'b1, O_CPU1, 1'b0, 1'b0, 1'b1};
    tbl[ 8] = '{1'b0, 1'b0, O_VID,  1'b0, 1'b1, 1'b0};
    tbl[ 9] = '{1'b0, 1'b0, O_IDLE, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, O_VID,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, O_CPU0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, O_VID,  1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, O_IDLE, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, O_VID,  1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, O_CPU1, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, O_VID,  1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, O_CPU0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, O_VID,  1'b1, 1'b0, 1'b0};

    // Reset with both requests high and ticks running.
    step();
    mem_load = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ack0", cpu0_ack, 0);
    chk("rst_ack1", cpu1_ack, 0);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_dout0", cpu0_dout, 0);
    chk("rst_dout1", cpu1_dout, 0);
    RSTn = 1'b1;
    div = 2; ph = 2'd0;
    step();
    step();
    chk("post_rst_owner", owner, O_IDLE);
    chk("post_rst_addr", ram_addr, 0);

    // Table: one tick per entry, then three idle clocks of the slot.
    we_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      cpu0_req = tbl[i].r0;
      cpu1_req = tbl[i].r1;
      step();
      chk($sformatf("tbl%0d_owner", i), owner, tbl[i].own);
      chk($sformatf("tbl%0d_ack0", i), cpu0_ack, tbl[i].a0);
      chk($sformatf("tbl%0d_ack1", i), cpu1_ack, tbl[i].a1);
      chk($sformatf("tbl%0d_vv", i), vid_valid, tbl[i].vv);
      if (i == 1) begin
        chk("rd_addr", ram_addr, 12'h123);
        chk("rd_we", ram_we, 0);
      end
      if (i == 2) chk("rd_dout0", cpu0_dout, 8'hA5);
      if (i == 3) begin
        chk("wr_addr", ram_addr, 12'h7FF);
        chk("wr_wdata", ram_wdata, 8'h3C);
        we_cnt += int'(ram_we);
      end
      if (i == 4) begin
        chk("wr_we_cycles", we_cnt, 4);
        chk("wr_ram_content", mem[12'h7FF], 8'h3C);
        chk("wr_we_off", ram_we, 0);
      end
      for (int k = 0; k < 3; k++) begin
        step();
        if (i == 3) we_cnt += int'(ram_we);
      end
    end
    cpu0_req = 1'b0; cpu1_req = 1'b0;

    // Video protection: cpu1 request raised just before a video phase.
    vid_addr = 12'h040;
    run_until(2'd2);
    cpu1_req = 1'b1; cpu1_we = 1'b0; cpu1_addr = 12'h055;
    step();
    chk("vp_owner_vid", owner, O_VID);
    chk("vp_addr_vid", ram_addr, 12'h040);
    repeat (3) step();
    step();
    chk("vp_valid", vid_valid, 1);
    chk("vp_vid_data", vid_data, init_val(12'h040));
    chk("vp_owner_cpu1", owner, O_CPU1);
    chk("vp_addr_cpu1", ram_addr, 12'h055);
    repeat (3) step();
    step();
    chk("vp_ack1", cpu1_ack, 1);
    chk("vp_dout1", cpu1_dout, init_val(12'h055));
    cpu1_req = 1'b0;

    // Reset two clocks into a cpu0 write slot.
    run_until(2'd1);
    cpu0_req = 1'b1; cpu0_we = 1'b1; cpu0_addr = 12'h200; cpu0_din = 8'h77;
    step();
    chk("mr_we_on", ram_we, 1);
    step();
    #1;
    RSTn = 1'b0;
    #1;
    chk("mr_we_async_off", ram_we, 0);
    chk("mr_owner_async", owner, O_IDLE);
    cpu0_req = 1'b0;
    step();
    step();
    RSTn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      pulses += int'(cpu0_ack);
    end
    chk("mr_no_ack", pulses, 0);
    cpu0_req = 1'b1; cpu0_we = 1'b0; cpu0_addr = 12'h123;
    wait_ack(0, seen);
    chk("mr_fresh_ack", seen, 1);
    chk("mr_fresh_dout", cpu0_dout, 8'hA5);
    cpu0_req = 1'b0;

    // No clock enable: a pending request must wait, nothing pulses.
    cen_en = 0;
    cpu1_req = 1'b1; cpu1_we = 1'b0; cpu1_addr = 12'h7FF;
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      pulses += int'(cpu1_ack) + int'(cpu0_ack) + int'(vid_valid);
    end
    chk("nocen_pulses", pulses, 0);
    cen_en = 1;
    wait_ack(1, seen);
    chk("nocen_then_ack", seen, 1);
    chk("nocen_dout1", cpu1_dout, 8'h3C);
    cpu1_req = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2400; n++) begin
      vid_addr = 12'($urandom_range(0, 63));
      if (!cpu0_req) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu0_req  = 1'b1;
          cpu0_we   = 1'($urandom_range(0, 1));
          cpu0_addr = 12'($urandom_range(0, 63));
          cpu0_din  = 8'($urandom_range(0, 255));
        end
      end else if (cpu0_ack) begin
        cpu0_req = 1'b0;
      end else if (m_owner != O_CPU0 && $urandom_range(0, 15) == 0) begin
        cpu0_req = 1'b0;
      end
      if (!cpu1_req) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu1_req  = 1'b1;
          cpu1_we   = 1'($urandom_range(0, 1));
          cpu1_addr = 12'($urandom_range(0, 63));
          cpu1_din  = 8'($urandom_range(0, 255));
        end
      end else if (cpu1_ack) begin
        cpu1_req = 1'b0;
      end else if (m_owner != O_CPU1 && $urandom_range(0, 15) == 0) begin
        cpu1_req = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
